// File: rtl/sobel_dsm_writer.sv
// sobel_dsm_writer: device-status-memory writer for the Sobel AFU.
//
// When the kernel signals completion, one 64-byte status line is written over
// CCI-P channel 1 to the host DSM line at hc_dsm_base. The write's response is
// matched by mdata and marks the status as globally visible.
//
// Ports:
//   clk, reset     AFU clock, synchronous active-high reset
//   hc_dsm_base    cache-line address of the DSM line (sampled at finish)
//   hc_start       one-cycle pulse, kernel started (clears counter, leaves DONE)
//   hc_finish      one-cycle pulse, kernel finished; hc_status/hc_lines valid
//   hc_status      kernel status code
//   hc_lines       number of output lines produced
//   c1TxAlmFull    c1 Tx almost-full back-pressure
//   rx_wr_channel  c1 Rx write responses
//   tx_wr_channel  c1 Tx write request (registered)
//   dsm_busy       write pending or in flight
//   dsm_done       status line visible; held until the next hc_start
//
// Build option: define SOBEL_DSM_PERF_EN to build the 64-bit saturating cycle
// counter reported in word 1; otherwise word 1 is zero and no counter exists.
//
// The CCI-P types below are the subset of the channel-1 definitions this block
// uses; they keep the design self-contained.

package sobel_dsm_ccip_pkg;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic         sop;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         hit_miss;
    logic         format;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;
endpackage

module sobel_dsm_writer
  import sobel_dsm_ccip_pkg::*;
#(
  parameter logic [15:0] DSM_MDATA = 16'hD5A0
) (
  input  logic           clk,
  input  logic           reset,
  input  t_ccip_clAddr   hc_dsm_base,
  input  logic           hc_start,
  input  logic           hc_finish,
  input  logic [31:0]    hc_status,
  input  logic [31:0]    hc_lines,
  input  logic           c1TxAlmFull,
  input  t_if_ccip_c1_Rx rx_wr_channel,
  output t_if_ccip_c1_Tx tx_wr_channel,
  output logic           dsm_busy,
  output logic           dsm_done
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRsp,
    StDone
  } state_e;

  state_e         state_q, state_d;
  t_if_ccip_c1_Tx tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [63:0]    cycle_count;
  logic           rsp_match;

  assign rsp_match = rx_wr_channel.rspValid &&
                     (rx_wr_channel.hdr.resp_type == eRSP_WRLINE) &&
                     (rx_wr_channel.hdr.mdata == DSM_MDATA);

  // Response header fields this block does not look at.
  logic unused_rx;
  assign unused_rx = ^{rx_wr_channel.hdr.vc_used, rx_wr_channel.hdr.hit_miss,
                       rx_wr_channel.hdr.format, rx_wr_channel.hdr.cl_num};

`ifdef SOBEL_DSM_PERF_EN
  logic [63:0] counter_q, counter_d;
  logic        running_q, running_d;

  // Counts from the cycle after a start until finish is captured. A start in
  // the same IDLE cycle as a finish is swallowed so the pre-start count is kept.
  always_comb begin
    counter_d = counter_q;
    running_d = running_q;
    if ((state_q == StIdle) && hc_finish) begin
      running_d = 1'b0;
    end else if (hc_start && ((state_q == StIdle) || (state_q == StDone))) begin
      counter_d = 64'h0;
      running_d = 1'b1;
    end else if (running_q && (counter_q != {64{1'b1}})) begin
      counter_d = counter_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= 64'h0;
      running_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      running_q <= running_d;
    end
  end

  assign cycle_count = counter_q;
`else
  assign cycle_count = 64'h0;
`endif

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    tx_d.valid   = 1'b0;
    done_d       = done_q;

    unique case (state_q)
      StIdle: begin
        if (hc_finish) begin
          // Header and line are latched here so later input changes cannot
          // disturb the pending write.
          state_d              = StIssue;
          tx_d.hdr.vc_sel      = eVC_VA;
          tx_d.hdr.sop         = 1'b1;
          tx_d.hdr.cl_len      = eCL_LEN_1;
          tx_d.hdr.req_type    = eREQ_WRLINE_I;
          tx_d.hdr.address     = hc_dsm_base;
          tx_d.hdr.mdata       = DSM_MDATA;
          tx_d.data            = {256'h0, {32'h0, hc_lines}, {32'h0, hc_status},
                                  cycle_count, 64'h1};
          tx_d.valid           = ~c1TxAlmFull;
        end
      end
      StIssue: begin
        // Stay here until the request has been presented for its one cycle.
        if (tx_q.valid) begin
          state_d = StWaitRsp;
        end else if (!c1TxAlmFull) begin
          tx_d.valid = 1'b1;
        end
      end
      StWaitRsp: begin
        if (rsp_match) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        if (hc_start) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StIssue) || (state_d == StWaitRsp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      tx_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_wr_channel = tx_q;
  assign dsm_busy      = busy_q;
  assign dsm_done      = done_q;

endmodule

// File: tb/tb_sobel_dsm_writer.sv
// Self-checking bench for sobel_dsm_writer: a table of transactions, hand-written
// reset/ignored-event sequences and randomized transactions, each checked
// against expectations derived from the block's behavioural rules.
module tb_sobel_dsm_writer;
  import sobel_dsm_ccip_pkg::*;

  localparam logic [15:0] MD = 16'hD5A0;
`ifdef SOBEL_DSM_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  t_ccip_clAddr   hc_dsm_base;
  logic           hc_start;
  logic           hc_finish;
  logic [31:0]    hc_status;
  logic [31:0]    hc_lines;
  logic           c1TxAlmFull;
  t_if_ccip_c1_Rx rx;
  t_if_ccip_c1_Tx tx;
  logic           dsm_busy;
  logic           dsm_done;

  sobel_dsm_writer #(.DSM_MDATA(MD)) dut (
    .clk          (clk),
    .reset        (reset),
    .hc_dsm_base  (hc_dsm_base),
    .hc_start     (hc_start),
    .hc_finish    (hc_finish),
    .hc_status    (hc_status),
    .hc_lines     (hc_lines),
    .c1TxAlmFull  (c1TxAlmFull),
    .rx_wr_channel(rx),
    .tx_wr_channel(tx),
    .dsm_busy     (dsm_busy),
    .dsm_done     (dsm_done)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    valid_cnt = 0;
  string cur_tag = "reset";

  // Independent count of every cycle the request is presented.
  always @(negedge clk) if (tx.valid === 1'b1) valid_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [41:0] base;
    int          idle;
    logic [31:0] status;
    logic [31:0] lines;
    int          af;
    int          rsp_dly;
    bit          ign_start;
    bit          ign_finish;
    bit          bad_rsp;
    bit          same_start;
    int          exp_lat;
    logic [63:0] exp_w1;
  } vec_t;

  // Expected results follow directly from the rules: the request appears the
  // cycle after almost-full is first seen low (it is raised for af cycles from
  // finish), and word 1 holds the number of idle cycles between start and finish.
  function automatic vec_t mk(input logic [41:0] base, input int idle, input logic [31:0] st,
                              input logic [31:0] ln, input int af, input int dly,
                              input bit is, input bit ifn, input bit br, input bit ss);
    vec_t v;
    v.base = base; v.idle = idle; v.status = st; v.lines = ln; v.af = af; v.rsp_dly = dly;
    v.ign_start = is; v.ign_finish = ifn; v.bad_rsp = br; v.same_start = ss;
    v.exp_lat = af + 1;
    v.exp_w1  = PERF ? 64'(idle) : 64'h0;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h required %0h", cur_tag, name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rsp(input t_ccip_c1_rsp t, input logic [15:0] md);
    rx = '0;
    rx.rspValid = 1'b1;
    rx.hdr.resp_type = t;
    rx.hdr.mdata = md;
    step();
    rx = '0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int lat;
    int v0;
    bit got;
    cur_tag = tag;
    v0 = valid_cnt;
    hc_start = 1'b1;
    step();
    hc_start = 1'b0;
    check("done_after_start", dsm_done, 1'b0);
    check("busy_after_start", dsm_busy, 1'b0);
    repeat (v.idle) step();
    hc_finish   = 1'b1;
    hc_start    = v.same_start;
    hc_status   = v.status;
    hc_lines    = v.lines;
    hc_dsm_base = v.base;
    c1TxAlmFull = (v.af > 0);
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 100 && !got; i++) begin
      step();
      hc_finish   = 1'b0;
      hc_start    = (v.ign_start && i == 1);
      hc_dsm_base = ~v.base;
      hc_status   = ~v.status;
      hc_lines    = ~v.lines;
      c1TxAlmFull = (i < v.af);
      lat = i;
      if (tx.valid === 1'b1) got = 1'b1;
    end
    hc_start = 1'b0;
    check("valid_seen", got, 1'b1);
    check("valid_latency", lat, v.exp_lat);
    check("busy_on_issue", dsm_busy, 1'b1);
    check("vc_sel", tx.hdr.vc_sel, eVC_VA);
    check("sop", tx.hdr.sop, 1'b1);
    check("cl_len", tx.hdr.cl_len, eCL_LEN_1);
    check("req_type", tx.hdr.req_type, eREQ_WRLINE_I);
    check("address", tx.hdr.address, v.base);
    check("mdata", tx.hdr.mdata, MD);
    check("w0", tx.data[63:0], 64'h1);
    check("w1", tx.data[127:64], v.exp_w1);
    check("w2", tx.data[191:128], {32'h0, v.status});
    check("w3", tx.data[255:192], {32'h0, v.lines});
    check("w4_w7_zero", (tx.data[511:256] == '0), 1'b1);
    step();
    check("valid_one_cycle", tx.valid, 1'b0);
    check("busy_wait", dsm_busy, 1'b1);
    if (v.ign_finish) begin
      hc_finish = 1'b1;
      hc_status = 32'hDEAD_BEEF;
      step();
      hc_finish = 1'b0;
    end
    if (v.bad_rsp) begin
      send_rsp(eRSP_WRLINE, 16'h0001);
      check("done_bad_mdata", dsm_done, 1'b0);
      send_rsp(eRSP_WRFENCE, MD);
      check("done_bad_type", dsm_done, 1'b0);
    end
    repeat (v.rsp_dly) step();
    check("done_before_rsp", dsm_done, 1'b0);
    check("busy_before_rsp", dsm_busy, 1'b1);
    send_rsp(eRSP_WRLINE, MD);
    check("done_after_rsp", dsm_done, 1'b1);
    check("busy_after_rsp", dsm_busy, 1'b0);
    step();
    check("done_held", dsm_done, 1'b1);
    check("write_count", valid_cnt - v0, 1);
  endtask

  vec_t tbl[6];

  initial begin
    int v0;
    reset = 1'b1; hc_dsm_base = '0; hc_start = 1'b0; hc_finish = 1'b0;
    hc_status = '0; hc_lines = '0; c1TxAlmFull = 1'b0; rx = '0;

    //               base            idle status        lines  af dly is ifn br ss
    tbl[0] = mk(42'h1000,          100, 32'h0,        32'd480, 0,  5, 0, 0, 0, 0);
    tbl[1] = mk(42'h3FF_FFFF_FFFF,   0, 32'hFFFF_FFFF, 32'd1, 20,  0, 0, 0, 0, 0);
    tbl[2] = mk(42'h2A5,             7, 32'h3,        32'd9,   1,  2, 0, 0, 1, 0);
    tbl[3] = mk(42'h1_2345_6789,    12, 32'h55,       32'd77,  5,  1, 1, 1, 0, 0);
    tbl[4] = mk(42'h40,             30, 32'h7,        32'd640, 0,  3, 0, 0, 0, 1);
    tbl[5] = mk(42'h80,              1, 32'hA5A5_0F0F, 32'd2,  3,  1, 0, 0, 0, 0);

    repeat (3) step();
    check("tx_zero", (tx == '0), 1'b1);
    check("valid", tx.valid, 1'b0);
    check("busy", dsm_busy, 1'b0);
    check("done", dsm_done, 1'b0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Reset while waiting for the response; the late response must be ignored.
    cur_tag = "reset_mid";
    hc_start = 1'b1; step(); hc_start = 1'b0;
    repeat (4) step();
    hc_finish = 1'b1; hc_dsm_base = 42'h777; step(); hc_finish = 1'b0;
    check("valid_pre_reset", tx.valid, 1'b1);
    step();
    check("busy_pre_reset", dsm_busy, 1'b1);
    v0 = valid_cnt;
    reset = 1'b1; step(); reset = 1'b0;
    check("tx_zero", (tx == '0), 1'b1);
    check("busy", dsm_busy, 1'b0);
    check("done", dsm_done, 1'b0);
    send_rsp(eRSP_WRLINE, MD);
    check("done_late_rsp", dsm_done, 1'b0);
    repeat (3) step();
    check("done_stays", dsm_done, 1'b0);
    check("busy_stays", dsm_busy, 1'b0);
    check("no_write", valid_cnt - v0, 0);

    for (int i = 0; i < 8; i++) begin
      logic [63:0] r;
      vec_t v;
      r = {$urandom(), $urandom()};
      v = mk(r[41:0], $urandom_range(0, 150), $urandom(), $urandom(),
             $urandom_range(0, 12), $urandom_range(0, 8), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
